fft4_stream_ctrl: RTL and testbench

//  Sequencer for the team's 4-point radix-2 FFT core, which is purely combinational.

---
 rtl/fft4_stream_ctrl.sv | 120 ++++++++++++
 tb/tb_fft4_stream_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft4_stream_ctrl.sv
// Sequencer for the combinational 4-point FFT core: it collects four serial samples,
// captures the core's eight result words and streams four bins out with backpressure.
module fft4_stream_ctrl #(
  parameter int DW   = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic [DW-1:0]   core_x_0,
  output logic [DW-1:0]   core_x_1,
  output logic [DW-1:0]   core_x_2,
  output logic [DW-1:0]   core_x_3,
  input  logic [DW-1:0]   core_re_0,
  input  logic [DW-1:0]   core_re_1,
  input  logic [DW-1:0]   core_re_2,
  input  logic [DW-1:0]   core_re_3,
  input  logic [DW-1:0]   core_im_0,
  input  logic [DW-1:0]   core_im_1,
  input  logic [DW-1:0]   core_im_2,
  input  logic [DW-1:0]   core_im_3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_real,
  output logic [DW-1:0]   out_imag,
  output logic [1:0]      out_idx,
  output logic            out_last,
  output logic [CNTW-1:0] frames_done
);

  typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [1:0]           scnt_q, scnt_d;
  logic [1:0]           bcnt_q, bcnt_d;
  logic [3:0][DW-1:0]   x_q, x_d;
  logic [3:0][DW-1:0]   re_q, re_d;
  logic [3:0][DW-1:0]   im_q, im_d;
  logic [CNTW-1:0]      frames_q, frames_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      scnt_q   <= '0;
      bcnt_q   <= '0;
      x_q      <= '0;
      re_q     <= '0;
      im_q     <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      bcnt_q   <= bcnt_d;
      x_q      <= x_d;
      re_q     <= re_d;
      im_q     <= im_d;
      frames_q <= frames_d;
    end
  end

  // Flush wins over everything; samples and captured results are kept, only the counters restart.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bcnt_d   = bcnt_q;
    x_d      = x_q;
    re_d     = re_q;
    im_d     = im_q;
    frames_d = frames_q;
    if (flush) begin
      state_d = LOAD;
      scnt_d  = '0;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            x_d[scnt_q] = in_data;
            scnt_d      = scnt_q + 2'd1;
            if (scnt_q == 2'd3) state_d = CALC;
          end
        end
        CALC: begin
          re_d    = {core_re_3, core_re_2, core_re_1, core_re_0};
          im_d    = {core_im_3, core_im_2, core_im_1, core_im_0};
          bcnt_d  = '0;
          state_d = DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              state_d  = LOAD;
              frames_d = frames_q + CNTW'(1);
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_comb begin
    in_ready    = (state_q == LOAD);
    out_valid   = (state_q == DRAIN);
    out_idx     = bcnt_q;
    out_last    = (state_q == DRAIN) && (bcnt_q == 2'd3);
    out_real    = re_q[bcnt_q];
    out_imag    = im_q[bcnt_q];
    core_x_0    = x_q[0];
    core_x_1    = x_q[1];
    core_x_2    = x_q[2];
    core_x_3    = x_q[3];
    frames_done = frames_q;
  end

endmodule

// File: tb/tb_fft4_stream_ctrl.sv
// Bench for fft4_stream_ctrl: wraps the controller around a model of the team's
// 4-point core and scoreboards every output bin against the samples sent in.
module tb_fft4_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [3:0] in_data, out_real, out_imag;
  logic [1:0] out_idx;
  logic [1:0] frames_done;
  logic [3:0] cx0, cx1, cx2, cx3, cre0, cre1, cre2, cre3, cim0, cim1, cim2, cim3;

  typedef struct packed {
    logic [3:0] re;
    logic [3:0] im;
    logic [1:0] idx;
    logic       last;
  } bin_t;

  bin_t       sbQ[$];
  logic [3:0] frameBuf[$];
  int         total = 0;
  int         bad = 0;
  int         readyMode = 0;
  int         stallLeft = 0;
  logic [1:0] expFrames = 2'd0;
  logic       chkFramesPending = 1'b0;
  logic       holdActive = 1'b0;
  logic [3:0] heldRe, heldIm;
  logic [1:0] heldIdx;
  logic       heldLast;

  fft4_stream_ctrl #(.DW(4), .CNTW(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_x_0(cx0), .core_x_1(cx1), .core_x_2(cx2), .core_x_3(cx3),
    .core_re_0(cre0), .core_re_1(cre1), .core_re_2(cre2), .core_re_3(cre3),
    .core_im_0(cim0), .core_im_1(cim1), .core_im_2(cim2), .core_im_3(cim3),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real),
    .out_imag(out_imag), .out_idx(out_idx), .out_last(out_last),
    .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  // Model of the team's combinational core: adjacent-pair butterflies, 4-bit wrap.
  always_comb begin
    cre0 = cx0 + cx1 + cx2 + cx3;
    cim0 = 4'd0;
    cre1 = cx0 + cx1 - cx2 - cx3;
    cim1 = 4'd0;
    cre2 = cx0 - cx1;
    cim2 = cx2 - cx3;
    cre3 = cx0 - cx1;
    cim3 = cx3 - cx2;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bins for one frame, computed from the samples as they were accepted.
  task automatic pushModel(input logic [3:0] s0, s1, s2, s3);
    logic [3:0] a, b, c, d;
    a = s0 + s1;
    b = s0 - s1;
    c = s2 + s3;
    d = s2 - s3;
    sbQ.push_back('{re: a + c, im: 4'd0, idx: 2'd0, last: 1'b0});
    sbQ.push_back('{re: a - c, im: 4'd0, idx: 2'd1, last: 1'b0});
    sbQ.push_back('{re: b,     im: d,    idx: 2'd2, last: 1'b0});
    sbQ.push_back('{re: b,     im: 4'd0 - d, idx: 2'd3, last: 1'b1});
  endtask

  task automatic pushRef();
    sbQ.push_back('{re: 4'd10, im: 4'd0,  idx: 2'd0, last: 1'b0});
    sbQ.push_back('{re: 4'd12, im: 4'd0,  idx: 2'd1, last: 1'b0});
    sbQ.push_back('{re: 4'd15, im: 4'd15, idx: 2'd2, last: 1'b0});
    sbQ.push_back('{re: 4'd15, im: 4'd1,  idx: 2'd3, last: 1'b1});
  endtask

  task automatic applyStimulus(input logic [3:0] v, input int gap, input bit autoPush);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) checkOutput("inReadyTimeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
    if (!flush) frameBuf.push_back(v);
    if (frameBuf.size() == 4) begin
      if (autoPush) pushModel(frameBuf[0], frameBuf[1], frameBuf[2], frameBuf[3]);
      frameBuf.delete();
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sbQ.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) checkOutput("drainTimeout", sbQ.size(), 0);
    tick();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstFrames", frames_done, 0);
    checkOutput("rstIdx", out_idx, 0);
    checkOutput("rstLast", out_last, 0);
    checkOutput("rstCoreX", {cx3, cx2, cx1, cx0}, 0);
    sbQ.delete();
    frameBuf.delete();
    expFrames = 2'd0;
    chkFramesPending = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rstInReady", in_ready, 1);
  endtask

  // Consumer: drives out_ready after each edge according to the scenario's pattern.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: out_ready = 1'b1;
      1: begin
        if (out_valid && out_idx == 2'd2 && stallLeft > 0) begin
          out_ready = 1'b0;
          stallLeft--;
        end else out_ready = ~out_ready;
      end
      2: out_ready = 1'b0;
      default: out_ready = out_valid && (out_idx == 2'd0);
    endcase
  end

  // Monitor: a bin is consumed at the next edge when valid & ready are both high mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chkFramesPending) begin
        checkOutput("framesDone", frames_done, expFrames);
        checkOutput("inReadyAfterLast", in_ready, 1);
        chkFramesPending = 1'b0;
      end
      if (out_valid) checkOutput("inReadyDrain", in_ready, 0);
      if (out_valid && holdActive) begin
        checkOutput("holdRe", out_real, heldRe);
        checkOutput("holdIm", out_imag, heldIm);
        checkOutput("holdIdx", out_idx, heldIdx);
        checkOutput("holdLast", out_last, heldLast);
      end
      if (out_valid && out_ready && !flush) begin
        holdActive = 1'b0;
        if (sbQ.size() == 0) checkOutput("unexpectedBin", sbQ.size(), 1);
        else begin
          bin_t e;
          e = sbQ.pop_front();
          checkOutput("binRe", out_real, e.re);
          checkOutput("binIm", out_imag, e.im);
          checkOutput("binIdx", out_idx, e.idx);
          checkOutput("binLast", out_last, e.last);
          if (e.last) begin
            expFrames = expFrames + 2'd1;
            chkFramesPending = 1'b1;
          end
        end
      end else if (out_valid && !out_ready) begin
        holdActive = 1'b1;
        heldRe = out_real;
        heldIm = out_imag;
        heldIdx = out_idx;
        heldLast = out_last;
      end else holdActive = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [1:0] savedFrames;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = 4'd0;
    out_ready = 1'b0;
    repeat (3) tick();
    doReset();

    // Basic frame with latency check.
    pushRef();
    applyStimulus(4'd1, 0, 1'b0);
    applyStimulus(4'd2, 0, 1'b0);
    applyStimulus(4'd3, 0, 1'b0);
    applyStimulus(4'd4, 0, 1'b0);
    checkOutput("calcValid", out_valid, 0);
    checkOutput("calcInReady", in_ready, 0);
    tick();
    checkOutput("latencyValid", out_valid, 1);
    waitDrain();
    checkOutput("framesAfterFirst", frames_done, 1);

    // Reset in the middle of DRAIN.
    readyMode = 2;
    applyStimulus(4'd9, 0, 1'b1);
    applyStimulus(4'd1, 0, 1'b1);
    applyStimulus(4'd2, 0, 1'b1);
    applyStimulus(4'd3, 0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checkOutput("preResetValid", out_valid, 1);
    doReset();
    readyMode = 0;

    // Backpressure: toggling ready plus a long stall on bin 2.
    stallLeft = 5;
    readyMode = 1;
    pushRef();
    for (int k = 1; k <= 4; k++) applyStimulus(4'(k), 0, 1'b0);
    waitDrain();
    readyMode = 0;

    // Sparse input of zeros.
    for (int k = 0; k < 4; k++) applyStimulus(4'd0, 2, 1'b1);
    waitDrain();

    // Flush after two samples, with a third sample offered in the flush cycle.
    applyStimulus(4'd7, 0, 1'b1);
    applyStimulus(4'd7, 0, 1'b1);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd9;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    frameBuf.delete();
    checkOutput("flushInReady", in_ready, 1);
    checkOutput("flushDiscard", cx2, 0);
    pushRef();
    for (int k = 1; k <= 4; k++) applyStimulus(4'(k), 0, 1'b0);
    waitDrain();

    // Flush while bin 1 is stalled in DRAIN.
    readyMode = 3;
    for (int k = 5; k <= 8; k++) applyStimulus(4'(k), 0, 1'b1);
    n = 0;
    while (!(out_valid && out_idx == 2'd1) && n < 30) begin tick(); n++; end
    checkOutput("reachBin1", out_idx, 1);
    savedFrames = expFrames;
    flush = 1'b1;
    sbQ.delete();
    tick();
    flush = 1'b0;
    checkOutput("flushDrainValid", out_valid, 0);
    checkOutput("flushDrainFrames", frames_done, savedFrames);
    readyMode = 0;
    tick();

    // Five back-to-back frames: the 2-bit counter runs 1,2,3,0,1.
    doReset();
    for (int f = 0; f < 5; f++)
      for (int k = 0; k < 4; k++) applyStimulus(4'($urandom_range(0, 15)), 0, 1'b1);
    waitDrain();
    checkOutput("wrapFrames", frames_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
